// File: rtl/dco_sdm_pkg.sv
// dco_sdm_pkg: shared constants, order encodings, LFSR taps and carry-to-signed helper for dco_sdm_ctrl
package dco_sdm_pkg;
  localparam int INT_W_C = 8;
  localparam int FRAC_W_C = 8;
  localparam int LFSR_W = 15;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 15'h6000;
  localparam int Y_W = 4;
  typedef enum logic [1:0] {
    SDM_BYPASS = 2'd0,
    SDM_O1     = 2'd1,
    SDM_O2     = 2'd2,
    SDM_O3     = 2'd3
  } sdm_order_e;
  function automatic logic signed [Y_W-1:0] cy(input logic c);
    return $signed({{(Y_W-1){1'b0}}, c});
  endfunction
endpackage

// File: rtl/sdm_acc_stage.sv
// sdm_acc_stage: W-bit wrapping accumulator; in clk/rstn/en/clr/din/cin, out sum (next value, comb) and carry (registered)
module sdm_acc_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] din,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         carry
);
  logic [W-1:0] acc;
  logic [W:0] nxt;
  assign nxt = {1'b0, acc} + {1'b0, din} + {{W{1'b0}}, cin};
  assign sum = nxt[W-1:0];
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc <= '0;
      carry <= 1'b0;
    end else if (clr) begin
      acc <= '0;
      carry <= 1'b0;
    end else if (en) begin
      acc <= sum;
      carry <= nxt[W];
    end
  end
endmodule

// File: rtl/dco_sdm_ctrl.sv
// dco_sdm_ctrl: MASH 1-1-1 noise-shaped split of ctrl_word into saturated dco_code; in clk/rstn/enable/ctrl_load/ctrl_word/sdm_order/dither_en, out dco_code/sat_flag/load_ack
module dco_sdm_ctrl
  import dco_sdm_pkg::*;
#(
  parameter int INT_W = INT_W_C,
  parameter int FRAC_W = FRAC_W_C,
  parameter logic [LFSR_W-1:0] LFSR_SEED = 15'h0001
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    enable,
  input  logic                    ctrl_load,
  input  logic [INT_W+FRAC_W-1:0] ctrl_word,
  input  logic [1:0]              sdm_order,
  input  logic                    dither_en,
  output logic [INT_W-1:0]        dco_code,
  output logic                    sat_flag,
  output logic                    load_ack
);
  logic [INT_W-1:0] int_q;
  logic [FRAC_W-1:0] frac_q, sum1, sum2, sum3;
  logic [LFSR_W-1:0] lfsr;
  logic act, s2_on, s3_on;
  logic c1, c2, c3, c2d, c3d, c3dd;
  logic signed [Y_W-1:0] y;
  logic [INT_W+1:0] sum;
  logic neg, ovf;
  assign act = enable && sdm_order != SDM_BYPASS;
  assign s2_on = act && (sdm_order == SDM_O2 || sdm_order == SDM_O3);
  assign s3_on = act && sdm_order == SDM_O3;
  sdm_acc_stage #(.W(FRAC_W)) u_acc1 (
    .clk(clk), .rstn(rstn), .en(act), .clr(!act),
    .din(frac_q), .cin(dither_en & lfsr[0]), .sum(sum1), .carry(c1)
  );
  sdm_acc_stage #(.W(FRAC_W)) u_acc2 (
    .clk(clk), .rstn(rstn), .en(act), .clr(!s2_on),
    .din(sum1), .cin(1'b0), .sum(sum2), .carry(c2)
  );
  sdm_acc_stage #(.W(FRAC_W)) u_acc3 (
    .clk(clk), .rstn(rstn), .en(act), .clr(!s3_on),
    .din(sum2), .cin(1'b0), .sum(sum3), .carry(c3)
  );
  always_comb begin
    y = !act ? '0 :
        sdm_order == SDM_O1 ? cy(c1) :
        sdm_order == SDM_O2 ? cy(c1) + cy(c2) - cy(c2d) :
        cy(c1) + cy(c2) - cy(c2d) + cy(c3) - cy(c3d) - cy(c3d) + cy(c3dd);
    sum = {2'b00, int_q} + {{(INT_W+2-Y_W){y[Y_W-1]}}, y};
    neg = sum[INT_W+1];
    ovf = !neg && sum[INT_W];
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      int_q <= '0;
      frac_q <= '0;
      lfsr <= LFSR_SEED;
      c2d <= 1'b0;
      c3d <= 1'b0;
      c3dd <= 1'b0;
      dco_code <= '0;
      sat_flag <= 1'b0;
      load_ack <= 1'b0;
    end else begin
      if (ctrl_load && enable) {int_q, frac_q} <= ctrl_word;
      load_ack <= ctrl_load && enable;
      lfsr <= !act ? LFSR_SEED : dither_en ? {lfsr[LFSR_W-2:0], ^(lfsr & LFSR_TAPS)} : lfsr;
      c2d <= s2_on && c2;
      c3d <= s3_on && c3;
      c3dd <= s3_on && c3d;
      dco_code <= neg ? '0 : ovf ? '1 : sum[INT_W-1:0];
      sat_flag <= neg || ovf;
    end
  end
  logic unused;
  assign unused = ^sum3;
endmodule

// File: tb/tb_dco_sdm_ctrl.sv
// tb_dco_sdm_ctrl: directed and randomized checks of dco_sdm_ctrl against an arithmetic MASH reference model
module tb_dco_sdm_ctrl;
  logic clk = 1'b0;
  logic rstn, enable, ctrl_load, dither_en, sat_flag, load_ack;
  logic [15:0] ctrl_word;
  logic [1:0] sdm_order;
  logic [7:0] dco_code;
  int checks = 0, errors = 0;
  int m_int, m_frac, a1, a2, a3, q1, q2, q3, d2, d3, d33, lf;
  int e_code, e_sat, e_ack;
  int ysum, msum, sat_cnt, msat_cnt, prev;
  always #5 clk = ~clk;
  dco_sdm_ctrl dut (
    .clk(clk), .rstn(rstn), .enable(enable), .ctrl_load(ctrl_load),
    .ctrl_word(ctrl_word), .sdm_order(sdm_order), .dither_en(dither_en),
    .dco_code(dco_code), .sat_flag(sat_flag), .load_ack(load_ack)
  );
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_int = 0; m_frac = 0; a1 = 0; a2 = 0; a3 = 0;
    q1 = 0; q2 = 0; q3 = 0; d2 = 0; d3 = 0; d33 = 0; lf = 1;
    e_code = 0; e_sat = 0; e_ack = 0;
  endtask
  task automatic model_step();
    int y, s, t, n1, n2, n3, c1, c2, c3, din, ord;
    bit act;
    ord = int'(sdm_order);
    act = enable && ord != 0;
    y = !act ? 0 : ord == 1 ? q1 : ord == 2 ? q1 + q2 - d2 : q1 + q2 - d2 + q3 - 2 * d3 + d33;
    s = m_int + y;
    e_code = s < 0 ? 0 : s > 255 ? 255 : s;
    e_sat = (s < 0 || s > 255) ? 1 : 0;
    e_ack = (ctrl_load && enable) ? 1 : 0;
    if (act) begin
      din = dither_en ? lf % 2 : 0;
      t = a1 + m_frac + din; n1 = t % 256; c1 = t / 256;
      n2 = 0; c2 = 0; n3 = 0; c3 = 0;
      if (ord >= 2) begin t = a2 + n1; n2 = t % 256; c2 = t / 256; end
      if (ord == 3) begin t = a3 + n2; n3 = t % 256; c3 = t / 256; end
      d33 = ord == 3 ? d3 : 0;
      d3 = ord == 3 ? q3 : 0;
      d2 = ord >= 2 ? q2 : 0;
      a1 = n1; a2 = n2; a3 = n3; q1 = c1; q2 = c2; q3 = c3;
      if (dither_en) lf = ((lf * 2) % 32768) | (((lf >> 14) ^ (lf >> 13)) & 1);
    end else begin
      a1 = 0; a2 = 0; a3 = 0; q1 = 0; q2 = 0; q3 = 0; d2 = 0; d3 = 0; d33 = 0; lf = 1;
    end
    if (e_ack == 1) begin
      m_int = int'(ctrl_word) / 256;
      m_frac = int'(ctrl_word) % 256;
    end
  endtask
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("dco_code", int'(dco_code), e_code);
    chk("sat_flag", int'(sat_flag), e_sat);
    chk("load_ack", int'(load_ack), e_ack);
    ysum += int'(dco_code);
    msum += e_code;
    sat_cnt += int'(sat_flag);
    msat_cnt += e_sat;
  endtask
  task automatic load(input logic [15:0] w);
    ctrl_word = w;
    ctrl_load = 1'b1;
    tick();
    ctrl_load = 1'b0;
  endtask
  task automatic clr_stats();
    ysum = 0; msum = 0; sat_cnt = 0; msat_cnt = 0;
  endtask
  initial begin
    rstn = 1'b0; enable = 1'b0; ctrl_load = 1'b0; ctrl_word = '0; sdm_order = 2'd0; dither_en = 1'b0;
    model_reset();
    clr_stats();
    #12;
    chk("rst_code", int'(dco_code), 0);
    chk("rst_sat", int'(sat_flag), 0);
    chk("rst_ack", int'(load_ack), 0);
    @(negedge clk);
    rstn = 1'b1;
    enable = 1'b1; sdm_order = 2'd3;
    load(16'h4A00);
    chk("t1_ack_hi", int'(load_ack), 1);
    tick();
    chk("t1_ack_lo", int'(load_ack), 0);
    for (int i = 0; i < 20; i++) begin
      chk("t1_code", int'(dco_code), 'h4A);
      chk("t1_sat", int'(sat_flag), 0);
      tick();
    end
    sdm_order = 2'd1;
    load(16'h1080);
    tick();
    clr_stats();
    prev = int'(dco_code);
    for (int i = 0; i < 256; i++) begin
      tick();
      if (i == 0) chk("t2_first", int'(dco_code), 'h10);
      else chk("t2_alt", int'(dco_code != 8'(prev) && (dco_code == 8'h10 || dco_code == 8'h11)), 1);
      prev = int'(dco_code);
    end
    chk("t2_sum", ysum, 256 * 16 + 128);
    enable = 1'b0;
    tick();
    enable = 1'b1; sdm_order = 2'd3;
    load(16'h2040);
    repeat (8) tick();
    clr_stats();
    for (int i = 0; i < 256; i++) begin
      tick();
      chk("t3_range", int'(dco_code >= 8'h1D && dco_code <= 8'h24), 1);
    end
    chk("t3_sum_model", ysum, msum);
    chk("t3_sum_near", int'(ysum >= 256 * 32 + 60 && ysum <= 256 * 32 + 68), 1);
    load(16'hFFC0);
    clr_stats();
    for (int i = 0; i < 256; i++) begin
      tick();
      chk("t4_hi_clip", int'(!sat_flag || dco_code == 8'hFF), 1);
    end
    chk("t4_hi_satcnt", sat_cnt, msat_cnt);
    chk("t4_hi_seen", int'(sat_cnt > 0), 1);
    load(16'h0010);
    repeat (4) tick();
    clr_stats();
    for (int i = 0; i < 256; i++) begin
      tick();
      chk("t4_lo_clip", int'(!sat_flag || dco_code == 8'h00), 1);
    end
    chk("t4_lo_satcnt", sat_cnt, msat_cnt);
    chk("t4_lo_seen", int'(sat_cnt > 0), 1);
    enable = 1'b0;
    tick();
    enable = 1'b1; dither_en = 1'b1;
    load(16'h5000);
    clr_stats();
    for (int i = 0; i < 4096; i++) tick();
    chk("t5_sum_model", ysum, msum);
    chk("t5_mean", int'(ysum - 4096 * 'h50 >= 2 && ysum - 4096 * 'h50 <= 24), 1);
    dither_en = 1'b0;
    load(16'h2040);
    repeat (10) tick();
    #2 rstn = 1'b0;
    #1;
    chk("arst_code", int'(dco_code), 0);
    chk("arst_sat", int'(sat_flag), 0);
    chk("arst_ack", int'(load_ack), 0);
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
    load(16'h3000);
    tick();
    chk("t6_code", int'(dco_code), 'h30);
    enable = 1'b0;
    load(16'h7700);
    chk("t6_noack", int'(load_ack), 0);
    enable = 1'b1;
    tick();
    chk("t6_nocap", int'(dco_code), 'h30);
    for (int i = 0; i < 3000; i++) begin
      enable = $urandom_range(0, 15) != 0;
      ctrl_load = $urandom_range(0, 7) == 0;
      ctrl_word = 16'($urandom);
      if ($urandom_range(0, 63) == 0) sdm_order = 2'($urandom);
      if ($urandom_range(0, 31) == 0) dither_en = ~dither_en;
      tick();
    end
    ctrl_load = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
